// File: rtl/float_arith_unit.sv
// Multi-cycle floating-point add/sub/mul for the LM32 coprocessor.
// Format {sign, NE-bit biased exponent, NM-bit mantissa with hidden 1}.
// Pipeline of FSM states: IDLE -> UNPACK -> OP -> NORM -> ROUND -> OUT.
// Rounding is round-to-nearest-even. Results that leave the exponent range
// saturate to exp all-ones or flush to zero; no denormals are produced.
module float_arith_unit #(
  parameter int NM = 23,
  parameter int NE = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [NE+NM:0] a,
  input  logic [NE+NM:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [NE+NM:0] result,
  output logic           flag_zero,
  output logic           flag_ovf,
  output logic           flag_unf,
  output logic           flag_inexact
);

  localparam int W   = 1 + NE + NM;
  localparam int MW  = NM + 1;        // mantissa including hidden bit
  localparam int XW  = MW + 4;        // carry + mantissa + guard/round/sticky
  localparam int EW  = NE + 2;        // signed working exponent
  localparam int LZW = $clog2(XW);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (NE - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << NE) - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_OP     = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  logic [2:0] state;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);

  // Control FSM; one operation in flight, each state lasts one cycle except OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (in_valid) state <= S_UNPACK;
        S_UNPACK: state <= S_OP;
        S_OP:     state <= S_NORM;
        S_NORM:   state <= S_ROUND;
        S_ROUND:  state <= S_OUT;
        S_OUT:    if (out_ready) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // ---------------- operand capture ----------------
  logic [W-1:0] a_q, b_q;
  logic [1:0]   op_q;

  // Register operands and opcode on the accepting edge.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

  // ---------------- UNPACK ----------------
  logic          sa_u, sb_u, za_u, zb_u, ia_u, ib_u;
  logic [NE-1:0] ea_u, eb_u;
  logic [MW-1:0] ma_u, mb_u;

  // Split fields, restore hidden bits, classify zero / exp-all-ones operands.
  always_ff @(posedge clk) begin
    if (state == S_UNPACK) begin
      sa_u <= a_q[W-1];
      sb_u <= b_q[W-1];
      ea_u <= a_q[W-2:NM];
      eb_u <= b_q[W-2:NM];
      ma_u <= {1'b1, a_q[NM-1:0]};
      mb_u <= {1'b1, b_q[NM-1:0]};
      za_u <= (a_q[W-2:NM] == '0);
      zb_u <= (b_q[W-2:NM] == '0);
      ia_u <= &a_q[W-2:NM];
      ib_u <= &b_q[W-2:NM];
    end
  end

  // ---------------- OP ----------------
  logic                 is_mul, sbe, swap, big_s, eff_sub;
  logic [NE-1:0]        big_e, sml_e, diff;
  logic [MW-1:0]        big_m, sml_m;
  logic [MW+2:0]        ext, sh, aln;
  logic [2*MW-1:0]      prod;
  logic [XW-1:0]        sum_c;
  logic signed [EW-1:0] exp_c;
  logic                 sgn_c, byp_c, byp_ovf_c;
  logic [W-1:0]         byp_res_c;

  // Magnitude-ordered align-and-add, or full mantissa product; special operands bypass.
  always_comb begin
    is_mul  = (op_q == 2'b10);
    sbe     = sb_u ^ (op_q == 2'b01);
    swap    = {eb_u, mb_u} > {ea_u, ma_u};
    big_s   = swap ? sbe  : sa_u;
    big_e   = swap ? eb_u : ea_u;
    big_m   = swap ? mb_u : ma_u;
    sml_e   = swap ? ea_u : eb_u;
    sml_m   = swap ? ma_u : mb_u;
    diff    = big_e - sml_e;
    ext     = {sml_m, 3'b000};
    sh      = ext >> diff;
    // Beyond guard+round the smaller operand survives only as sticky.
    if (int'(diff) > MW + 2) aln = {{(MW+2){1'b0}}, 1'b1};
    else                     aln = {sh[MW+2:1], sh[0] | ((sh << diff) != ext)};
    eff_sub = sa_u ^ sbe;
    prod    = (2*MW)'(ma_u) * (2*MW)'(mb_u);

    if (is_mul) begin
      // Product lies in [1,4): top bit lands in the carry slot.
      sum_c = {prod[2*MW-1:MW-3], |prod[MW-4:0]};
      exp_c = $signed({2'b00, ea_u}) + $signed({2'b00, eb_u}) - BIAS;
      sgn_c = sa_u ^ sb_u;
    end else begin
      sum_c = eff_sub ? ({1'b0, big_m, 3'b000} - {1'b0, aln})
                      : ({1'b0, big_m, 3'b000} + {1'b0, aln});
      exp_c = $signed({2'b00, big_e});
      sgn_c = big_s;
    end

    byp_c     = 1'b1;
    byp_ovf_c = 1'b0;
    byp_res_c = '0;
    if (ia_u || ib_u) begin
      byp_ovf_c = 1'b1;
      byp_res_c = {sgn_c, {NE{1'b1}}, {NM{1'b0}}};
    end else if (is_mul && (za_u || zb_u)) begin
      byp_res_c = {sgn_c, {(NE+NM){1'b0}}};
    end else if (!is_mul && za_u) begin
      byp_res_c = {sbe, b_q[W-2:0]};
    end else if (!is_mul && zb_u) begin
      byp_res_c = a_q;
    end else begin
      byp_c = 1'b0;
    end
  end

  logic [XW-1:0]        x_q;
  logic signed [EW-1:0] xe_q;
  logic                 xs_q, byp_q, byp_ovf_q;
  logic [W-1:0]         byp_res_q;

  // Register raw arithmetic result and any bypass result.
  always_ff @(posedge clk) begin
    if (state == S_OP) begin
      x_q       <= sum_c;
      xe_q      <= exp_c;
      xs_q      <= sgn_c;
      byp_q     <= byp_c;
      byp_ovf_q <= byp_ovf_c;
      byp_res_q <= byp_res_c;
    end
  end

  // ---------------- NORM ----------------
  logic [LZW-1:0]       lz;
  logic [MW+2:0]        n_c;
  logic signed [EW-1:0] ne_c;
  logic                 nz_c;

  // Bring the leading one to the hidden-bit position, keeping sticky intact.
  always_comb begin
    lz   = '0;
    nz_c = 1'b0;
    n_c  = x_q[XW-2:0];
    ne_c = xe_q;
    if (x_q[XW-1]) begin
      n_c  = {x_q[XW-1:2], x_q[1] | x_q[0]};
      ne_c = xe_q + EW'(1);
    end else begin
      for (int i = 0; i < XW - 1; i++)
        if (x_q[i]) lz = LZW'(XW - 2 - i);
      nz_c = ~|x_q[XW-2:0];
      n_c  = x_q[XW-2:0] << lz;
      ne_c = xe_q - EW'(lz);
    end
  end

  logic [MW+2:0]        n_q;
  logic signed [EW-1:0] ne_q;
  logic                 ns_q, nz_q;

  // Register normalised mantissa/exponent.
  always_ff @(posedge clk) begin
    if (state == S_NORM) begin
      n_q  <= n_c;
      ne_q <= ne_c;
      ns_q <= xs_q;
      nz_q <= nz_c;
    end
  end

  // ---------------- ROUND ----------------
  logic                 g, r, st, up, inx;
  logic [MW:0]          mr;
  logic [MW-1:0]        mant_c;
  logic signed [EW-1:0] re_c;
  logic [W-1:0]         res_c;
  logic                 ovf_c, unf_c, inx_c;

  // Round to nearest even, then saturate or flush out-of-range exponents.
  always_comb begin
    g   = n_q[2];
    r   = n_q[1];
    st  = n_q[0];
    inx = g | r | st;
    up  = g & (r | st | n_q[3]);
    mr  = {1'b0, n_q[MW+2:3]} + (MW+1)'(up);
    if (mr[MW]) begin
      mant_c = mr[MW:1];
      re_c   = ne_q + EW'(1);
    end else begin
      mant_c = mr[MW-1:0];
      re_c   = ne_q;
    end

    ovf_c = 1'b0;
    unf_c = 1'b0;
    inx_c = 1'b0;
    if (byp_q) begin
      res_c = byp_res_q;
      ovf_c = byp_ovf_q;
    end else if (nz_q) begin
      res_c = '0;
    end else if (re_c >= EMAX) begin
      res_c = {ns_q, {NE{1'b1}}, {NM{1'b0}}};
      ovf_c = 1'b1;
      inx_c = inx;
    end else if (re_c <= 0) begin
      res_c = {ns_q, {(NE+NM){1'b0}}};
      unf_c = 1'b1;
      inx_c = inx;
    end else begin
      res_c = {ns_q, re_c[NE-1:0], mant_c[NM-1:0]};
      inx_c = inx;
    end
  end

  // Output registers; held through OUT until the consumer takes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      result       <= '0;
      flag_zero    <= 1'b0;
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_inexact <= 1'b0;
    end else if (state == S_ROUND) begin
      result       <= res_c;
      flag_zero    <= (res_c[W-2:NM] == '0);
      flag_ovf     <= ovf_c;
      flag_unf     <= unf_c;
      flag_inexact <= inx_c;
    end
  end

endmodule
